// File: rtl/vx_afu_axi_arb.sv
// Two-to-one AXI4 arbiter sharing one memory bank between the Vortex core (s0) and an AFU engine (s1).
// AW/AR are round-robin with grant lock, W follows AW grant order, B/R are routed by the ID MSB.
module vx_afu_axi_arb #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int ID_WIDTH        = 16,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                 ap_clk,
  input  logic                                 ap_rst_n,

  input  logic                                 s0_axi_awvalid,
  output logic                                 s0_axi_awready,
  input  logic [ADDR_WIDTH-1:0]                s0_axi_awaddr,
  input  logic [ID_WIDTH-2:0]                  s0_axi_awid,
  input  logic [7:0]                           s0_axi_awlen,
  input  logic                                 s0_axi_wvalid,
  output logic                                 s0_axi_wready,
  input  logic [DATA_WIDTH-1:0]                s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]              s0_axi_wstrb,
  input  logic                                 s0_axi_wlast,
  output logic                                 s0_axi_bvalid,
  input  logic                                 s0_axi_bready,
  output logic [ID_WIDTH-2:0]                  s0_axi_bid,
  output logic [1:0]                           s0_axi_bresp,
  input  logic                                 s0_axi_arvalid,
  output logic                                 s0_axi_arready,
  input  logic [ADDR_WIDTH-1:0]                s0_axi_araddr,
  input  logic [ID_WIDTH-2:0]                  s0_axi_arid,
  input  logic [7:0]                           s0_axi_arlen,
  output logic                                 s0_axi_rvalid,
  input  logic                                 s0_axi_rready,
  output logic [DATA_WIDTH-1:0]                s0_axi_rdata,
  output logic                                 s0_axi_rlast,
  output logic [ID_WIDTH-2:0]                  s0_axi_rid,
  output logic [1:0]                           s0_axi_rresp,

  input  logic                                 s1_axi_awvalid,
  output logic                                 s1_axi_awready,
  input  logic [ADDR_WIDTH-1:0]                s1_axi_awaddr,
  input  logic [ID_WIDTH-2:0]                  s1_axi_awid,
  input  logic [7:0]                           s1_axi_awlen,
  input  logic                                 s1_axi_wvalid,
  output logic                                 s1_axi_wready,
  input  logic [DATA_WIDTH-1:0]                s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]              s1_axi_wstrb,
  input  logic                                 s1_axi_wlast,
  output logic                                 s1_axi_bvalid,
  input  logic                                 s1_axi_bready,
  output logic [ID_WIDTH-2:0]                  s1_axi_bid,
  output logic [1:0]                           s1_axi_bresp,
  input  logic                                 s1_axi_arvalid,
  output logic                                 s1_axi_arready,
  input  logic [ADDR_WIDTH-1:0]                s1_axi_araddr,
  input  logic [ID_WIDTH-2:0]                  s1_axi_arid,
  input  logic [7:0]                           s1_axi_arlen,
  output logic                                 s1_axi_rvalid,
  input  logic                                 s1_axi_rready,
  output logic [DATA_WIDTH-1:0]                s1_axi_rdata,
  output logic                                 s1_axi_rlast,
  output logic [ID_WIDTH-2:0]                  s1_axi_rid,
  output logic [1:0]                           s1_axi_rresp,

  output logic                                 m_axi_awvalid,
  input  logic                                 m_axi_awready,
  output logic [ADDR_WIDTH-1:0]                m_axi_awaddr,
  output logic [ID_WIDTH-1:0]                  m_axi_awid,
  output logic [7:0]                           m_axi_awlen,
  output logic                                 m_axi_wvalid,
  input  logic                                 m_axi_wready,
  output logic [DATA_WIDTH-1:0]                m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]              m_axi_wstrb,
  output logic                                 m_axi_wlast,
  input  logic                                 m_axi_bvalid,
  output logic                                 m_axi_bready,
  input  logic [ID_WIDTH-1:0]                  m_axi_bid,
  input  logic [1:0]                           m_axi_bresp,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  output logic [ADDR_WIDTH-1:0]                m_axi_araddr,
  output logic [ID_WIDTH-1:0]                  m_axi_arid,
  output logic [7:0]                           m_axi_arlen,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready,
  input  logic [DATA_WIDTH-1:0]                m_axi_rdata,
  input  logic                                 m_axi_rlast,
  input  logic [ID_WIDTH-1:0]                  m_axi_rid,
  input  logic [1:0]                           m_axi_rresp,

  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_pending,
  output logic                                 busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SID_WIDTH  = ID_WIDTH - 1;
  localparam int CNT_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_WIDTH  = $clog2(MAX_OUTSTANDING);

  // Requester-indexed views of the upstream ports
  logic [1:0]            s_awvalid, s_awready, s_wvalid, s_wready, s_wlast;
  logic [1:0]            s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [ADDR_WIDTH-1:0] s_awaddr [2];
  logic [ADDR_WIDTH-1:0] s_araddr [2];
  logic [SID_WIDTH-1:0]  s_awid   [2];
  logic [SID_WIDTH-1:0]  s_arid   [2];
  logic [7:0]            s_awlen  [2];
  logic [7:0]            s_arlen  [2];
  logic [DATA_WIDTH-1:0] s_wdata  [2];
  logic [STRB_WIDTH-1:0] s_wstrb  [2];

  assign s_awvalid   = {s1_axi_awvalid, s0_axi_awvalid};
  assign s_wvalid    = {s1_axi_wvalid,  s0_axi_wvalid};
  assign s_wlast     = {s1_axi_wlast,   s0_axi_wlast};
  assign s_bready    = {s1_axi_bready,  s0_axi_bready};
  assign s_arvalid   = {s1_axi_arvalid, s0_axi_arvalid};
  assign s_rready    = {s1_axi_rready,  s0_axi_rready};
  assign s_awaddr[0] = s0_axi_awaddr;
  assign s_awaddr[1] = s1_axi_awaddr;
  assign s_araddr[0] = s0_axi_araddr;
  assign s_araddr[1] = s1_axi_araddr;
  assign s_awid[0]   = s0_axi_awid;
  assign s_awid[1]   = s1_axi_awid;
  assign s_arid[0]   = s0_axi_arid;
  assign s_arid[1]   = s1_axi_arid;
  assign s_awlen[0]  = s0_axi_awlen;
  assign s_awlen[1]  = s1_axi_awlen;
  assign s_arlen[0]  = s0_axi_arlen;
  assign s_arlen[1]  = s1_axi_arlen;
  assign s_wdata[0]  = s0_axi_wdata;
  assign s_wdata[1]  = s1_axi_wdata;
  assign s_wstrb[0]  = s0_axi_wstrb;
  assign s_wstrb[1]  = s1_axi_wstrb;

  assign s0_axi_awready = s_awready[0];
  assign s1_axi_awready = s_awready[1];
  assign s0_axi_wready  = s_wready[0];
  assign s1_axi_wready  = s_wready[1];
  assign s0_axi_bvalid  = s_bvalid[0];
  assign s1_axi_bvalid  = s_bvalid[1];
  assign s0_axi_arready = s_arready[0];
  assign s1_axi_arready = s_arready[1];
  assign s0_axi_rvalid  = s_rvalid[0];
  assign s1_axi_rvalid  = s_rvalid[1];

  // Registered state
  logic                 aw_prio_reg, aw_prio_next;
  logic                 aw_lock_reg, aw_lock_next;
  logic                 aw_sel_reg;
  logic                 ar_prio_reg, ar_prio_next;
  logic                 ar_lock_reg, ar_lock_next;
  logic                 ar_sel_reg;
  logic [CNT_WIDTH-1:0] wr_pending_reg, wr_pending_next;
  logic [PTR_WIDTH-1:0] wfifo_wr_ptr_reg, wfifo_wr_ptr_next;
  logic [PTR_WIDTH-1:0] wfifo_rd_ptr_reg, wfifo_rd_ptr_next;
  logic [CNT_WIDTH-1:0] wfifo_count_reg, wfifo_count_next;
  logic                 wfifo_mem [MAX_OUTSTANDING];

  logic aw_sel, aw_gate, aw_open, aw_hs;
  logic ar_sel, ar_hs;
  logic w_head, w_open, w_hs, w_pop;
  logic b_tgt, b_hs, r_tgt;

  // AW arbiter; the cap only blocks a fresh selection, never a locked one
  assign aw_gate = !aw_lock_reg && (wr_pending_reg == CNT_WIDTH'(MAX_OUTSTANDING));
  assign aw_open = ap_rst_n && !aw_gate;
  assign aw_sel  = aw_lock_reg            ? aw_sel_reg  :
                   (s_awvalid == 2'b11)   ? aw_prio_reg : s_awvalid[1];

  assign m_axi_awvalid = aw_open && s_awvalid[aw_sel];
  assign m_axi_awaddr  = s_awaddr[aw_sel];
  assign m_axi_awid    = {aw_sel, s_awid[aw_sel]};
  assign m_axi_awlen   = s_awlen[aw_sel];
  assign aw_hs         = m_axi_awvalid && m_axi_awready;

  assign aw_lock_next  = m_axi_awvalid && !m_axi_awready;
  assign aw_prio_next  = aw_hs ? ~aw_sel : aw_prio_reg;

  // AR arbiter
  assign ar_sel = ar_lock_reg          ? ar_sel_reg  :
                  (s_arvalid == 2'b11) ? ar_prio_reg : s_arvalid[1];

  assign m_axi_arvalid = ap_rst_n && s_arvalid[ar_sel];
  assign m_axi_araddr  = s_araddr[ar_sel];
  assign m_axi_arid    = {ar_sel, s_arid[ar_sel]};
  assign m_axi_arlen   = s_arlen[ar_sel];
  assign ar_hs         = m_axi_arvalid && m_axi_arready;

  assign ar_lock_next  = m_axi_arvalid && !m_axi_arready;
  assign ar_prio_next  = ar_hs ? ~ar_sel : ar_prio_reg;

  // W path follows the requester recorded at the head of the grant-order FIFO
  assign w_head = wfifo_mem[wfifo_rd_ptr_reg];
  assign w_open = ap_rst_n && (wfifo_count_reg != '0);

  assign m_axi_wvalid = w_open && s_wvalid[w_head];
  assign m_axi_wdata  = s_wdata[w_head];
  assign m_axi_wstrb  = s_wstrb[w_head];
  assign m_axi_wlast  = s_wlast[w_head];
  assign w_hs         = m_axi_wvalid && m_axi_wready;
  assign w_pop        = w_hs && m_axi_wlast;

  // Response routing by ID MSB
  assign b_tgt        = m_axi_bid[ID_WIDTH-1];
  assign m_axi_bready = ap_rst_n && s_bready[b_tgt];
  assign b_hs         = m_axi_bvalid && m_axi_bready;
  assign s0_axi_bid   = m_axi_bid[ID_WIDTH-2:0];
  assign s1_axi_bid   = m_axi_bid[ID_WIDTH-2:0];
  assign s0_axi_bresp = m_axi_bresp;
  assign s1_axi_bresp = m_axi_bresp;

  assign r_tgt        = m_axi_rid[ID_WIDTH-1];
  assign m_axi_rready = ap_rst_n && s_rready[r_tgt];
  assign s0_axi_rid   = m_axi_rid[ID_WIDTH-2:0];
  assign s1_axi_rid   = m_axi_rid[ID_WIDTH-2:0];
  assign s0_axi_rdata = m_axi_rdata;
  assign s1_axi_rdata = m_axi_rdata;
  assign s0_axi_rlast = m_axi_rlast;
  assign s1_axi_rlast = m_axi_rlast;
  assign s0_axi_rresp = m_axi_rresp;
  assign s1_axi_rresp = m_axi_rresp;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign s_awready[gi] = aw_open  && (aw_sel == 1'(gi)) && m_axi_awready;
      assign s_arready[gi] = ap_rst_n && (ar_sel == 1'(gi)) && m_axi_arready;
      assign s_wready[gi]  = w_open   && (w_head == 1'(gi)) && m_axi_wready;
      assign s_bvalid[gi]  = ap_rst_n && (b_tgt  == 1'(gi)) && m_axi_bvalid;
      assign s_rvalid[gi]  = ap_rst_n && (r_tgt  == 1'(gi)) && m_axi_rvalid;
    end
  endgenerate

  // Next-state for FIFO pointers and write counter
  always_comb begin
    wfifo_wr_ptr_next = wfifo_wr_ptr_reg;
    wfifo_rd_ptr_next = wfifo_rd_ptr_reg;
    wfifo_count_next  = wfifo_count_reg;
    wr_pending_next   = wr_pending_reg;
    if (aw_hs) wfifo_wr_ptr_next = wfifo_wr_ptr_reg + PTR_WIDTH'(1);
    if (w_pop) wfifo_rd_ptr_next = wfifo_rd_ptr_reg + PTR_WIDTH'(1);
    case ({aw_hs, w_pop})
      2'b10:   wfifo_count_next = wfifo_count_reg + CNT_WIDTH'(1);
      2'b01:   wfifo_count_next = wfifo_count_reg - CNT_WIDTH'(1);
      default: wfifo_count_next = wfifo_count_reg;
    endcase
    case ({aw_hs, b_hs})
      2'b10:   wr_pending_next = wr_pending_reg + CNT_WIDTH'(1);
      2'b01:   wr_pending_next = (wr_pending_reg == '0) ? '0 : wr_pending_reg - CNT_WIDTH'(1);
      default: wr_pending_next = wr_pending_reg;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      aw_prio_reg      <= 1'b0;
      aw_lock_reg      <= 1'b0;
      aw_sel_reg       <= 1'b0;
      ar_prio_reg      <= 1'b0;
      ar_lock_reg      <= 1'b0;
      ar_sel_reg       <= 1'b0;
      wr_pending_reg   <= '0;
      wfifo_wr_ptr_reg <= '0;
      wfifo_rd_ptr_reg <= '0;
      wfifo_count_reg  <= '0;
    end else begin
      aw_prio_reg      <= aw_prio_next;
      aw_lock_reg      <= aw_lock_next;
      aw_sel_reg       <= aw_sel;
      ar_prio_reg      <= ar_prio_next;
      ar_lock_reg      <= ar_lock_next;
      ar_sel_reg       <= ar_sel;
      wr_pending_reg   <= wr_pending_next;
      wfifo_wr_ptr_reg <= wfifo_wr_ptr_next;
      wfifo_rd_ptr_reg <= wfifo_rd_ptr_next;
      wfifo_count_reg  <= wfifo_count_next;
    end
  end

  // Storage needs no reset: entries are only read while the count is non-zero
  always_ff @(posedge ap_clk) begin
    if (aw_hs) wfifo_mem[wfifo_wr_ptr_reg] <= aw_sel;
  end

  // A B response with nothing outstanding is a downstream protocol violation
  always_ff @(posedge ap_clk) begin
    if (ap_rst_n) assert (!(b_hs && wr_pending_reg == '0));
  end

  assign wr_pending = wr_pending_reg;
  assign busy       = ap_rst_n && ((wr_pending_reg != '0) || (wfifo_count_reg != '0));

endmodule

// File: doc/vx_afu_axi_arb.md
# vx_afu_axi_arb

Two-to-one AXI4 memory arbiter for one memory bank in the XRT AFU. It lets two requesters share a single `m_axi_mem` bank port: requester 0 is the Vortex core (`Vortex_axi` bank output) and requester 1 is an AFU-side engine such as a host copy or scope dump. It arbitrates AW and AR independently and orders W data by AW grant. It routes B and R responses back using the ID MSB, and it caps outstanding writes so the AFU "pending writes" logic has a single source.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width on all ports.
- `DATA_WIDTH`, default 512: data width; wstrb width is DATA_WIDTH/8.
- `ID_WIDTH`, default 16: downstream ID width. Upstream IDs are ID_WIDTH-1 bits.
- `MAX_OUTSTANDING`, default 16: maximum accepted-but-unacknowledged write bursts. Also the depth of the W-order FIFO. Power of 2, ≥2.

Ports (n = 0,1). Clock and reset:
- `ap_clk`, in, 1: the single clock.
- `ap_rst_n`, in, 1: reset, synchronous and active-low.

Upstream ports, per requester n:
- `s<n>_axi_aw{valid,ready,addr,id,len}`, in/out/in/in/in, 1/1/ADDR_WIDTH/ID_WIDTH-1/8: write address.
- `s<n>_axi_w{valid,ready,data,strb,last}`, in/out/in/in/in, 1/1/DATA_WIDTH/DATA_WIDTH/8/1: write data.
- `s<n>_axi_b{valid,ready,id,resp}`, out/in/out/out, 1/1/ID_WIDTH-1/2: write response.
- `s<n>_axi_ar{valid,ready,addr,id,len}`, in/out/in/in/in, 1/1/ADDR_WIDTH/ID_WIDTH-1/8: read address.
- `s<n>_axi_r{valid,ready,data,last,id,resp}`, out/in/out/out/out/out, 1/1/DATA_WIDTH/1/ID_WIDTH-1/2: read data.

Downstream ports:
- `m_axi_*`: same channel fields as upstream, with mirrored directions and ID_WIDTH-bit IDs.

Status outputs:
- `wr_pending`, out, $clog2(MAX_OUTSTANDING+1): count of write bursts accepted on AW with no B yet.
- `busy`, out, 1: asserted when `wr_pending`≠0 or the W-order FIFO is non-empty.

## Operation
Address arbitration (AW and AR each have their own arbiter):
- Each arbiter is round-robin with a 1-bit priority pointer. The pointer resets to requester 0.
- When both requesters are valid, the prioritized one wins. After a handshake to requester n, priority moves to requester 1-n.
- Grant lock: once `m_axi_awvalid` (resp. `m_axi_arvalid`) is asserted without ready, the selection is held until the handshake. Downstream addr, id and len therefore stay stable, as AXI requires.
- The loser's ready is 0.
- ID tagging: `m_axi_awid = {n, s<n>_axi_awid}`, and likewise for `m_axi_arid`.
- AW gating: if `wr_pending == MAX_OUTSTANDING`, then `m_axi_awvalid=0` and both `s_awready=0`. A burst already locked is not dropped, because gating is evaluated before the lock is taken.

W-order FIFO:
- Each AW handshake pushes n into the FIFO.
- W is forwarded only from the requester at the FIFO head. `m_axi_w*` mirrors that requester, and the other requester's wready is 0.
- A W handshake with wlast=1 pops the FIFO.
- When the FIFO is empty, `m_axi_wvalid=0` and both wready=0.
- There is no write-to-read bypass.

Response routing:
- B is routed by `m_axi_bid[ID_WIDTH-1]`. `m_axi_bready` equals the target's bready, and `s_bid = m_axi_bid[ID_WIDTH-2:0]`. The non-target's bvalid is 0.
- R is routed the same way by `rid` MSB.

Write counter:
- `wr_pending` increments by 1 on an AW handshake and decrements by 1 on a B handshake. It is unchanged when both occur in the same cycle.
- It never exceeds MAX_OUTSTANDING.
- A B handshake while `wr_pending==0` is a protocol error: simulation assertion, and the counter stays at 0.

## Timing
- AW/AR: combinational from upstream valid to downstream valid (0-cycle latency). Arbitration pointer and lock are registered.
- W: the first beat is forwarded at the earliest 1 cycle after its AW handshake. After that, beats are combinational pass-through at 1 beat/cycle.
- B/R: combinational pass-through, 0 cycles.
- Reset, while `ap_rst_n=0` at a clock edge:
  - FIFO is cleared, `wr_pending=0`, both pointers go to requester 0, and locks clear.
  - While `ap_rst_n` is low, all valid and ready outputs (up and down) are forced to 0, and `busy=0`.
  - Reset mid-burst abandons the burst; the external system must reset the bank as well.
- Simultaneous push and pop on the FIFO is legal, including when it is full, because the pop frees the slot for the next cycle only.

## Test plan
- **Single write.** s0 sends AW addr 0x1000, id 0x5, len 3, then 4 W beats; downstream returns B with bid 0x0005.
  - `m_axi_awid=0x0005`; 4 beats appear on m_axi_w, the last with wlast=1.
  - s0_bvalid asserts with bid 0x5, and s1_bvalid stays 0.
  - `wr_pending` goes 0→1→0.
- **Contending reads.** s0 and s1 hold arvalid continuously with ids 0x1 and 0x2, and m_arready=1.
  - Grants alternate s0,s1,s0,s1, with `m_axi_arid` = 0x0001, 0x8002, 0x0001, 0x8002.
  - An R beat with rid 0x8002 reaches s1 only.
- **Backpressure lock.** s0 sends AW addr 0x2000 with m_awready=0 for 3 cycles; s1 raises awvalid in cycle 1 while the s1 pointer has priority.
  - `m_axi_awaddr` holds 0x2000 for all 4 cycles.
  - s1 is granted in the cycle after the s0 handshake.
- **Outstanding cap.** With MAX_OUTSTANDING=4, send 4 single-beat writes with no B.
  - The 5th AW sees s_awready=0 and `wr_pending=4`.
  - Return one B: the 5th AW is accepted on the next cycle.
- **W ordering.** s1 AW (len 1) is granted, then s0 AW (len 0); s0 presents W first.
  - s0_wready stays 0 until s1's 2 beats complete with wlast.
  - s0's beat then passes, and `busy` deasserts after both B handshakes.
- **Reset mid-burst.** Drop ap_rst_n after beat 2 of a 4-beat write.
  - All valid/ready outputs are 0, `wr_pending=0` and `busy=0`.
  - After release, a new s1 write completes normally.
